spi_bus_arbiter: RTL

- Two-master, one-slave arbiter for the pipelined Wishbone-like SoC bus.
- Master 0 is the SPI slave bridge; master 1 is a local master (e.g. acquisition/DMA control).
- Shares the single register-bank bus between them, with round-robin priority, cycle locking and a bus-timeout watchdog.
- Timeouts abort stuck cycles so the SPI bridge cannot underrun indefinitely.

---
 rtl/spi_bus_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// Two-master, one-slave arbiter for the pipelined register-bank bus.
// Master 0 is the SPI slave bridge, master 1 a local master. Round-robin
// priority on ties, grant locked for the whole cycle, and a watchdog that
// aborts a cycle whose strobes go unacknowledged for TIMEOUT cycles.
//
// Handshake: a master owns the bus from the registered grant until it drops
// cyc. While granted, every cycle with cyc and stb high is an accepted strobe
// (there is no stall). Each ack_i retires one outstanding strobe and is
// forwarded only to the granted master. A master that is not granted sees
// ack=0, err=0 and dat=0, and its strobes are ignored.
module spi_bus_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MSB     = WIDTH - 1,
    parameter int ASB     = WIDTH - 2,
    parameter int TBITS   = 4,
    parameter int TIMEOUT = 12
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           m0_cyc_i,
    input  logic           m0_stb_i,
    input  logic           m0_we_i,
    input  logic [ASB:0]   m0_adr_i,
    input  logic [MSB:0]   m0_dat_i,
    output logic           m0_ack_o,
    output logic           m0_err_o,
    output logic [MSB:0]   m0_dat_o,
    input  logic           m1_cyc_i,
    input  logic           m1_stb_i,
    input  logic           m1_we_i,
    input  logic [ASB:0]   m1_adr_i,
    input  logic [MSB:0]   m1_dat_i,
    output logic           m1_ack_o,
    output logic           m1_err_o,
    output logic [MSB:0]   m1_dat_o,
    output logic           cyc_o,
    output logic           stb_o,
    output logic           we_o,
    output logic [ASB:0]   adr_o,
    output logic [MSB:0]   dat_o,
    input  logic           ack_i,
    input  logic [MSB:0]   dat_i,
    output logic [1:0]     gnt_o,
    output logic           timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // Counter value at the end of the last permitted stall cycle.
    localparam logic [TBITS-1:0] CNT_LAST = TBITS'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;     // master served last (0 or 1)
    logic             owner_q, owner_d;   // master holding GNTx / ABORT
    logic [TBITS-1:0] cnt_q, cnt_d;       // stall cycles without ack
    logic [1:0]       outst_q, outst_d;   // outstanding strobes, max 2
    logic             err_q, err_d;       // error pulse for the aborted master
    logic             tmo_q, tmo_d;       // sticky timeout flag

    logic             own_cyc;
    logic             oth_cyc;
    logic             accept;
    logic             pending;
    logic [2:0]       outst_sum;

    assign timeout_o = tmo_q;

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            outst_q <= 2'd0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state, watchdog and bus mux driven from the registered grant.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        outst_d   = outst_q;
        err_d     = 1'b0;
        tmo_d     = tmo_q;
        own_cyc   = 1'b0;
        oth_cyc   = 1'b0;
        accept    = 1'b0;
        pending   = 1'b0;
        outst_sum = 3'd0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        we_o      = 1'b0;
        adr_o     = '0;
        dat_o     = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        gnt_o     = 2'b00;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                outst_d = 2'd0;
                // Master 0 wins unless master 1 also asks and 0 was served last.
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    owner_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    owner_d = 1'b1;
                end
            end

            GNT0, GNT1: begin
                if (state_q == GNT0) begin
                    gnt_o    = 2'b01;
                    cyc_o    = m0_cyc_i;
                    stb_o    = m0_stb_i;
                    we_o     = m0_we_i;
                    adr_o    = m0_adr_i;
                    dat_o    = m0_dat_i;
                    m0_ack_o = ack_i;
                    m0_dat_o = dat_i;
                    own_cyc  = m0_cyc_i;
                    oth_cyc  = m1_cyc_i;
                end else begin
                    gnt_o    = 2'b10;
                    cyc_o    = m1_cyc_i;
                    stb_o    = m1_stb_i;
                    we_o     = m1_we_i;
                    adr_o    = m1_adr_i;
                    dat_o    = m1_dat_i;
                    m1_ack_o = ack_i;
                    m1_dat_o = dat_i;
                    own_cyc  = m1_cyc_i;
                    oth_cyc  = m0_cyc_i;
                end

                if (!own_cyc) begin
                    // Release: hand straight over if the other master waits.
                    last_d  = owner_q;
                    cnt_d   = '0;
                    outst_d = 2'd0;
                    if (oth_cyc) begin
                        state_d = owner_q ? GNT0 : GNT1;
                        owner_d = ~owner_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Track outstanding strobes; the strobe on the bus this
                    // cycle already counts as waiting for its ack.
                    accept    = cyc_o & stb_o;
                    pending   = (outst_q != 2'd0) || accept;
                    outst_sum = {1'b0, outst_q} + {2'b00, accept};
                    if (ack_i && (outst_sum != 3'd0)) begin
                        outst_sum = outst_sum - 3'd1;
                    end
                    if (outst_sum > 3'd2) begin
                        outst_sum = 3'd2;
                    end
                    outst_d = outst_sum[1:0];

                    // An ack always wins over the watchdog in the same cycle.
                    if (ack_i) begin
                        cnt_d = '0;
                    end else if (pending) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ABORT;
                            err_d   = 1'b1;
                            tmo_d   = 1'b1;
                            cnt_d   = '0;
                            outst_d = 2'd0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            ABORT: begin
                // Bus is parked; late acks are swallowed until the master lets go.
                gnt_o    = owner_q ? 2'b10 : 2'b01;
                m0_err_o = err_q & ~owner_q;
                m1_err_o = err_q & owner_q;
                own_cyc  = owner_q ? m1_cyc_i : m0_cyc_i;
                cnt_d    = '0;
                outst_d  = 2'd0;
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
